// File: rtl/cdb_arbiter_if.sv
// Result-bus interface between the functional units and cdb_arbiter.
// master = arbiter side, slave = producer/consumer side.
interface cdb_arbiter_if #(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned CDB_W   = 38
);
  localparam int unsigned PTR_W = $clog2(N_UNITS);

  logic [N_UNITS*CDB_W-1:0] i_cdb;
  logic [N_UNITS-1:0]       i_valid;
  logic [N_UNITS-1:0]       i_ready;
  logic [CDB_W-1:0]         cdb;
  logic                     cdb_valid;
  logic [PTR_W-1:0]         grant_ptr;

  modport master (
    input  i_cdb, i_valid,
    output i_ready, cdb, cdb_valid, grant_ptr
  );

  modport slave (
    output i_cdb, i_valid,
    input  i_ready, cdb, cdb_valid, grant_ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving the registered common data bus.
// Define CDB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, grant_ptr tied to 0).
module cdb_arbiter #(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned CDB_W   = 38
) (
  input logic           clk,
  input logic           nrst,
  input logic           clear,
  cdb_arbiter_if.master bus
);
  localparam int unsigned PTR_W = $clog2(N_UNITS);

  logic             flush;
  logic             found;
  logic [PTR_W-1:0] start;
  logic [PTR_W-1:0] gnt_idx;
  logic [CDB_W-1:0] sel_cdb;
  logic [N_UNITS-1:0] ready;
  int unsigned      k;

  assign flush = ~nrst | clear;

`ifdef CDB_ARB_FIXED_PRIO_EN
  always_comb start = '0;
`else
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;

  always_comb start = ptr;
  // Explicit wrap keeps non-power-of-two unit counts correct.
  always_comb ptr_next = (gnt_idx == PTR_W'(N_UNITS - 1)) ? '0 : gnt_idx + 1'b1;
`endif

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    k       = 0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      k = (32'(start) + i) % N_UNITS;
      if (!found && bus.i_valid[PTR_W'(k)]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(k);
      end
    end
  end

  always_comb begin
    sel_cdb = '0;
    ready   = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (gnt_idx == PTR_W'(i)) sel_cdb = bus.i_cdb[i*CDB_W +: CDB_W];
      ready[i] = found && !flush && (gnt_idx == PTR_W'(i));
    end
  end

  assign bus.i_ready = ready;

`ifdef CDB_ARB_FIXED_PRIO_EN
  assign bus.grant_ptr = '0;
`else
  assign bus.grant_ptr = ptr;
`endif

  always_ff @(posedge clk) begin
    if (flush) begin
      bus.cdb       <= '0;
      bus.cdb_valid <= 1'b0;
`ifndef CDB_ARB_FIXED_PRIO_EN
      ptr           <= '0;
`endif
    end else if (found) begin
      bus.cdb       <= sel_cdb;
      bus.cdb_valid <= 1'b1;
`ifndef CDB_ARB_FIXED_PRIO_EN
      ptr           <= ptr_next;
`endif
    end else begin
      bus.cdb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: scoreboard model plus directed vectors.
// Build with CDB_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority variant.
module tb_cdb_arbiter;
  localparam int N = 4;
  localparam int W = 38;

  logic clk = 1'b0;
  logic nrst;
  logic clear;

  int checks = 0;
  int errors = 0;

  cdb_arbiter_if #(.N_UNITS(N), .CDB_W(W)) bus ();

  cdb_arbiter #(.N_UNITS(N), .CDB_W(W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // model state
  bit         started = 1'b0;
  bit         m_valid = 1'b0;
  logic [W-1:0] m_cdb = '0;
  int         mptr = 0;
  int         last_grant = -1;
  int         rx_cnt = 0;
  logic [5:0] rx_q[$];
  int         seq = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int grant_of(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      int kk;
      kk = (p + i) % N;
      if (v[kk] === 1'b1) return kk;
    end
    return -1;
  endfunction

  // Compare outputs against the model, then advance the model to the next posedge.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    g = (!nrst || clear) ? -1 : grant_of(bus.i_valid, mptr);
    er = (g >= 0) ? N'(1 << g) : '0;
    if (started) begin
      chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
      if (m_valid) begin
        chk("cdb", 64'(bus.cdb), 64'(m_cdb));
        rx_q.push_back(m_cdb[W-1:32]);
        rx_cnt++;
      end
      chk("grant_ptr", 64'(bus.grant_ptr), 64'(mptr));
      chk("i_ready", 64'(bus.i_ready), 64'(er));
    end
    if (!nrst || clear) begin
      if (!nrst) started = 1'b1;
      m_valid    = 1'b0;
      mptr       = 0;
      last_grant = -1;
    end else if (g >= 0) begin
      m_cdb      = bus.i_cdb[g*W +: W];
      m_valid    = 1'b1;
`ifdef CDB_ARB_FIXED_PRIO_EN
      mptr       = 0;
`else
      mptr       = (g + 1) % N;
`endif
      last_grant = g;
    end else begin
      m_valid    = 1'b0;
      last_grant = -1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int u, input logic [5:0] id, input logic [31:0] d);
    bus.i_cdb[u*W +: W] = {id, d};
  endtask

  task automatic refresh(input int u);
    seq++;
    set_unit(u, 6'(16 + (seq % 40)), 32'(seq * 32'h0101_0003));
  endtask

  initial begin
    nrst        = 1'b0;
    clear       = 1'b0;
    bus.i_valid = '0;
    bus.i_cdb   = '0;
    tick();
    tick();
    nrst = 1'b1;

    for (int c = 0; c < 5; c++) begin
      #1;
      chk("idle_ready", 64'(bus.i_ready), 64'h0);
      chk("idle_ptr", 64'(bus.grant_ptr), 64'h0);
      chk("idle_valid", 64'(bus.cdb_valid), 64'h0);
      tick();
    end

`ifdef CDB_ARB_FIXED_PRIO_EN
    for (int u = 0; u < N; u++) refresh(u);
    bus.i_valid = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("fixed_ready", 64'(bus.i_ready), 64'b0001);
      chk("fixed_ptr", 64'(bus.grant_ptr), 64'h0);
      tick();
      refresh(0);
    end
    bus.i_valid = '0;
    tick();
    tick();
`else
    // single unit: unit 2 carries {id 3, 0xAB}
    set_unit(2, 6'd3, 32'h0000_00AB);
    bus.i_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(bus.i_ready), 64'b0100);
    tick();
    bus.i_valid = '0;
    #1;
    chk("single_valid", 64'(bus.cdb_valid), 64'h1);
    chk("single_cdb", 64'(bus.cdb), {26'h0, 6'd3, 32'h0000_00AB});
    chk("single_ptr", 64'(bus.grant_ptr), 64'd3);

    // wrap and skip from ptr=3
    set_unit(0, 6'd5, 32'h0000_0050);
    set_unit(1, 6'd6, 32'h0000_0060);
    bus.i_valid = 4'b0011;
    #1;
    chk("wrap_ready0", 64'(bus.i_ready), 64'b0001);
    tick();
    bus.i_valid = 4'b0010;
    #1;
    chk("wrap_ptr1", 64'(bus.grant_ptr), 64'd1);
    chk("wrap_ready1", 64'(bus.i_ready), 64'b0010);
    tick();
    bus.i_valid = '0;
    #1;
    chk("wrap_ptr2", 64'(bus.grant_ptr), 64'd2);
    chk("wrap_cdb", 64'(bus.cdb), {26'h0, 6'd6, 32'h0000_0060});

    nrst = 1'b0;
    tick();
    nrst = 1'b1;

    // all units valid continuously
    for (int u = 0; u < N; u++) refresh(u);
    bus.i_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      logic [3:0] exp_order;
      exp_order = 4'(1 << (c % 4));
      #1;
      chk("rr_order", 64'(bus.i_ready), 64'(exp_order));
      tick();
      if (last_grant >= 0) refresh(last_grant);
    end
    bus.i_valid = '0;
    tick();
`endif

    // clear during traffic, then drain and confirm nothing was lost
    for (int u = 0; u < N; u++) set_unit(u, 6'(40 + u), 32'(32'hC0DE_0000 + u));
    bus.i_valid = 4'b1111;
    clear = 1'b1;
    rx_cnt = 0;
    rx_q.delete();
    #1;
    chk("clear_ready", 64'(bus.i_ready), 64'h0);
    tick();
    clear = 1'b0;
    #1;
    chk("clear_valid", 64'(bus.cdb_valid), 64'h0);
    chk("clear_ptr", 64'(bus.grant_ptr), 64'h0);
    chk("clear_first", 64'(bus.i_ready), 64'b0001);
    for (int c = 0; c < 10; c++) begin
      if (bus.i_valid == '0) break;
      tick();
      if (last_grant >= 0) bus.i_valid[last_grant] = 1'b0;
    end
    chk("drain_done", 64'(bus.i_valid), 64'h0);
    tick();
    tick();
    chk("no_loss_count", 64'(rx_cnt), 64'd4);
    for (int u = 0; u < 4; u++) begin
      logic [5:0] got_id;
      got_id = (rx_q.size() > 0) ? rx_q.pop_front() : 6'h3F;
      chk("no_loss_order", 64'(got_id), 64'(40 + u));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits directly downstream of the functional units (ALU, FPU, load/store unit). Each unit presents a completed result as {rsv_id, data} with a valid/ready handshake.
- Grants at most one unit per cycle using round-robin priority. Drives the granted result onto the registered common data bus (cdb, cdb_valid).
- cdb and cdb_valid are broadcast to every reservation station and the register file. The bus has no back-pressure.

Parameters:
- N_UNITS, 4, number of result producers; legal range 2..8.
- CDB_W, fcpu_pkg::CDB_W, width of one bus word {RSV_ID_W rsv_id, DATA_W data}.

Ports:
- clk  input  1  clock, all state updates on posedge.
- nrst  input  1  synchronous active-low reset.
- clear  input  1  synchronous pipeline flush; same effect as reset.
- i_cdb  input  N_UNITS*CDB_W  unit k result at bits [k*CDB_W +: CDB_W].
- i_valid  input  N_UNITS  unit k has a result pending.
- i_ready  output  N_UNITS  one-hot grant; unit k result is consumed this cycle when i_valid[k] & i_ready[k].
- cdb  output  CDB_W  broadcast result word, registered.
- cdb_valid  output  1  cdb holds a valid result this cycle, registered.
- grant_ptr  output  $clog2(N_UNITS)  current highest-priority index, for debug and trace.

Behaviour:
- Reset and clear:
  - When (~nrst | clear) is sampled at posedge: cdb <= 0, cdb_valid <= 0, ptr <= 0.
  - i_ready is forced to all-zero combinationally while ~nrst | clear, so no result is consumed during a flush.
- Grant (combinational):
  - Search i_valid starting at index ptr, wrapping modulo N_UNITS. The first valid index g receives i_ready[g] = 1; all other bits are 0.
  - If no unit is valid, i_ready = 0.
  - i_ready depends on i_valid. Units must not make i_valid depend on i_ready.
- Bus register, at posedge when not in reset/clear:
  - If any i_valid: cdb <= i_cdb[g], cdb_valid <= 1, ptr <= (g+1) mod N_UNITS.
  - Else: cdb_valid <= 0, cdb holds its previous value, ptr unchanged.
- Latency: exactly 1 cycle from handshake to cdb_valid. Sustained throughput is one result per cycle.
- Fairness: a unit holding valid continuously is granted within N_UNITS cycles.
- A unit that is not granted must hold i_valid and i_cdb stable. The arbiter never drops or duplicates a result.
- Pointer wrap: g = N_UNITS-1 gives ptr <= 0.
- Simultaneous events:
  - A unit may present a new result in the cycle after its grant; it is then treated like any other request.
  - clear in the same cycle as a handshake: the result is not consumed (i_ready = 0) and the bus is not written.
- Reset mid-burst: pending requests stay pending; arbitration restarts from ptr = 0.
- cdb_valid is never X after the first reset. cdb content is don't-care while cdb_valid = 0.

Optional Feature:
- Macro: CDB_ARB_FIXED_PRIO_EN.
- Defined:
  - Arbitration is fixed priority: lowest valid index always wins and ptr is not updated.
  - grant_ptr is tied to 0.
  - Used when the ALU is index 0 and must never be stalled by long-latency units.
  - Starvation of high indices is permitted.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset then idle: nrst=0 for 2 cycles, then i_valid=0000 for 5 cycles -> cdb_valid=0, i_ready=0000, grant_ptr=0 throughout.
- Single unit: i_valid=0100, i_cdb[2]={id=3, data=32'h0000_00AB} -> i_ready=0100 that cycle; next cycle cdb_valid=1, cdb={3, 32'hAB}; grant_ptr=3.
- All units valid continuously for 8 cycles from ptr=0 -> grant order 0,1,2,3,0,1,2,3; cdb_valid=1 each cycle after the first, with matching rsv_ids.
- Wrap and skip: ptr=3, i_valid=0011 -> unit 0 granted, ptr=1; next cycle unit 1 granted, ptr=2.
- clear during traffic: i_valid=1111 and clear=1 for 1 cycle -> i_ready=0000; next cycle cdb_valid=0, ptr=0; after clear deasserts, unit 0 is granted first and no result is lost (scoreboard count equals request count).
- With CDB_ARB_FIXED_PRIO_EN: i_valid=1011 held for 3 cycles -> unit 0 granted each cycle, grant_ptr=0; units 1 and 3 are not granted.
